// File: rtl/conv_recv_if.sv
// conv_recv_if -- lane-byte / assembled-word bus for the PHY receive width converter.
//  in_data   : lane byte (driven by the lane side)
//  in_valid  : in_data valid this cycle
//  out       : assembled word, right-aligned for 16b/8b widths
//  out_valid : one-cycle pulse, out holds a complete word
//  err       : one-cycle pulse, partial word discarded or reserved-width byte
// master = lane side / consumer of words, slave = the converter.
interface conv_recv_if #(
   parameter int LANE_W = 8,
   parameter int WORD_W = 32
);
   logic [LANE_W-1:0] in_data;
   logic              in_valid;
   logic [WORD_W-1:0] out;
   logic              out_valid;
   logic              err;

   modport master (
      output in_data, in_valid,
      input  out, out_valid, err
   );

   modport slave (
      input  in_data, in_valid,
      output out, out_valid, err
   );
endinterface

// File: rtl/conv_recv.sv
// conv_recv -- receive side of the PHY width converter.
// Gathers 8-bit lane bytes into 32/16/8-bit words selected by PCLK. The first
// byte on the lane lands in the most-significant byte of the word.
// Ports:
//  CLK    : clock, rising edge
//  RESET  : synchronous active-high reset, overrides everything
//  ENB    : block enable; dropping it flushes any partial word
//  PCLK   : width select 00=32b, 01=16b, 10=8b, 11=reserved
//  bus    : conv_recv_if.slave (in_data/in_valid in, out/out_valid/err out)
module conv_recv #(
   parameter int LANE_W = 8,
   parameter int WORD_W = 32
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       ENB,
   input  logic [1:0] PCLK,
   conv_recv_if.slave bus
);

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t            state, state_n;
   logic [2:0]        byte_cnt, byte_cnt_n;
   logic [WORD_W-1:0] shift_reg, shift_reg_n;
   logic [1:0]        word_pclk, word_pclk_n;   // width the current partial word was started under
   logic [WORD_W-1:0] out_q, out_n;
   logic              vld_q, vld_n;
   logic              err_q, err_n;

   // bytes needed for a word at a given width; 0 marks the reserved code
   function automatic logic [2:0] target(input logic [1:0] p);
      case (p)
         2'b00:   target = 3'd4;
         2'b01:   target = 3'd2;
         2'b10:   target = 3'd1;
         default: target = 3'd0;
      endcase
   endfunction

   // keeps only the low N bytes, so stale bytes from earlier words never leak out
   function automatic logic [WORD_W-1:0] word_mask(input logic [2:0] n);
      case (n)
         3'd4:    word_mask = 32'hFFFF_FFFF;
         3'd2:    word_mask = 32'h0000_FFFF;
         3'd1:    word_mask = 32'h0000_00FF;
         default: word_mask = 32'h0000_0000;
      endcase
   endfunction

   logic [2:0]        tgt;
   logic              restart;
   logic [2:0]        cnt_inc;
   logic [WORD_W-1:0] acc;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         byte_cnt  <= 3'd0;
         shift_reg <= '0;
         word_pclk <= 2'b00;
         out_q     <= '0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_n;
         byte_cnt  <= byte_cnt_n;
         shift_reg <= shift_reg_n;
         word_pclk <= word_pclk_n;
         out_q     <= out_n;
         vld_q     <= vld_n;
         err_q     <= err_n;
      end
   end

   always_comb begin
      state_n     = state;
      byte_cnt_n  = byte_cnt;
      shift_reg_n = shift_reg;
      word_pclk_n = word_pclk;
      out_n       = out_q;
      vld_n       = 1'b0;
      err_n       = 1'b0;
      tgt         = target(PCLK);
      // a width change mid-word abandons the partial word; this byte starts a new one
      restart     = (byte_cnt != 3'd0) && (PCLK != word_pclk);
      cnt_inc     = (restart ? 3'd0 : byte_cnt) + 3'd1;
      acc         = restart ? {{(WORD_W-LANE_W){1'b0}}, bus.in_data}
                            : {shift_reg[WORD_W-LANE_W-1:0], bus.in_data};

      case (state)
         IDLE: begin
            // the enabling cycle itself never accepts a byte
            byte_cnt_n = 3'd0;
            if (ENB) state_n = COLLECT;
         end
         COLLECT: begin
            if (!ENB) begin
               state_n     = IDLE;
               err_n       = (byte_cnt != 3'd0);
               byte_cnt_n  = 3'd0;
               shift_reg_n = '0;
            end else if (bus.in_valid) begin
               if (tgt == 3'd0) begin
                  err_n       = 1'b1;
                  byte_cnt_n  = 3'd0;
                  shift_reg_n = '0;
               end else begin
                  err_n       = restart;
                  word_pclk_n = PCLK;
                  shift_reg_n = acc;
                  if (cnt_inc == tgt) begin
                     out_n      = acc & word_mask(tgt);
                     vld_n      = 1'b1;
                     byte_cnt_n = 3'd0;
                  end else begin
                     byte_cnt_n = cnt_inc;
                  end
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.out       = out_q;
   assign bus.out_valid = vld_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_conv_recv.sv
// tb_conv_recv -- directed vector table, a reset sequence and a randomized run
// against a byte-queue reference model of the receive converter.
module tb_conv_recv;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       ENB;
   logic [1:0] PCLK;

   conv_recv_if ifc ();

   conv_recv dut (
      .CLK   (CLK),
      .RESET (RESET),
      .ENB   (ENB),
      .PCLK  (PCLK),
      .bus   (ifc.slave)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        enb;
      logic [1:0]  pclk;
      logic        vld;
      logic [7:0]  d;
      logic [31:0] eo;
      logic        ev;
      logic        ee;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic enb, input logic [1:0] pclk, input logic vld,
                      input logic [7:0] d, input logic [31:0] eo,
                      input logic ev, input logic ee);
      vec_t v;
      v.enb = enb; v.pclk = pclk; v.vld = vld; v.d = d;
      v.eo = eo; v.ev = ev; v.ee = ee;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic [31:0] eo, input logic ev, input logic ee);
      chk({nm, ".out"},       ifc.out,              eo);
      chk({nm, ".out_valid"}, {31'b0, ifc.out_valid}, {31'b0, ev});
      chk({nm, ".err"},       {31'b0, ifc.err},       {31'b0, ee});
   endtask

   task automatic drive(input logic rst, input logic enb, input logic [1:0] pclk,
                        input logic vld, input logic [7:0] d);
      RESET = rst; ENB = enb; PCLK = pclk; ifc.in_valid = vld; ifc.in_data = d;
      @(posedge CLK);
      #1;
   endtask

   // reference model: bytes of the current word held in a queue
   bit          m_act;
   logic [7:0]  m_q[$];
   logic [1:0]  m_wp;
   logic [31:0] m_out;
   bit          m_v, m_e;

   function automatic int nbytes(input logic [1:0] p);
      return (p == 2'd0) ? 4 : (p == 2'd1) ? 2 : (p == 2'd2) ? 1 : 0;
   endfunction

   task automatic model(input logic rst, input logic enb, input logic [1:0] pclk,
                        input logic vld, input logic [7:0] d);
      logic [31:0] w;
      m_v = 0; m_e = 0;
      if (rst) begin
         m_act = 0; m_q.delete(); m_out = 0;
      end else if (!m_act) begin
         m_act = enb;
      end else if (!enb) begin
         m_e = (m_q.size() != 0);
         m_q.delete();
         m_act = 0;
      end else if (vld) begin
         if (nbytes(pclk) == 0) begin
            m_e = 1;
            m_q.delete();
         end else begin
            if (m_q.size() != 0 && pclk != m_wp) begin
               m_e = 1;
               m_q.delete();
            end
            m_wp = pclk;
            m_q.push_back(d);
            if (m_q.size() == nbytes(pclk)) begin
               w = 0;
               foreach (m_q[i]) w = (w << 8) | {24'b0, m_q[i]};
               m_out = w;
               m_v = 1;
               m_q.delete();
            end
         end
      end
   endtask

   initial begin
      logic        r, e, v;
      logic [1:0]  p;
      logic [7:0]  d;

      RESET = 1; ENB = 0; PCLK = 0; ifc.in_valid = 0; ifc.in_data = 0;
      drive(1, 0, 0, 0, 8'h00);
      drive(1, 1, 0, 1, 8'hAB);
      chk_all("reset", 32'h0, 1'b0, 1'b0);

      // 32b word, enabling cycle first
      add(1, 0, 0, 8'h00, 32'h0, 0, 0);
      add(1, 0, 1, 8'h0F, 32'h0, 0, 0);
      add(1, 0, 1, 8'h00, 32'h0, 0, 0);
      add(1, 0, 1, 8'hFF, 32'h0, 0, 0);
      add(1, 0, 1, 8'h55, 32'h0F00FF55, 1, 0);
      // continuous stream, pulses 4 apart
      add(1, 0, 1, 8'hAA, 32'h0F00FF55, 0, 0);
      add(1, 0, 1, 8'h0F, 32'h0F00FF55, 0, 0);
      add(1, 0, 1, 8'h00, 32'h0F00FF55, 0, 0);
      add(1, 0, 1, 8'hFF, 32'hAA0F00FF, 1, 0);
      add(1, 0, 1, 8'h0F, 32'hAA0F00FF, 0, 0);
      add(1, 0, 1, 8'hF0, 32'hAA0F00FF, 0, 0);
      add(1, 0, 1, 8'hFF, 32'hAA0F00FF, 0, 0);
      add(1, 0, 1, 8'h00, 32'h0FF0FF00, 1, 0);
      // 16b with holes, then 8b back-to-back
      add(1, 1, 1, 8'hAA, 32'h0FF0FF00, 0, 0);
      add(1, 1, 0, 8'h11, 32'h0FF0FF00, 0, 0);
      add(1, 1, 0, 8'h22, 32'h0FF0FF00, 0, 0);
      add(1, 1, 0, 8'h33, 32'h0FF0FF00, 0, 0);
      add(1, 1, 1, 8'hA0, 32'h0000AAA0, 1, 0);
      add(1, 2, 1, 8'h55, 32'h00000055, 1, 0);
      add(1, 2, 1, 8'hA1, 32'h000000A1, 1, 0);
      add(1, 2, 1, 8'hA2, 32'h000000A2, 1, 0);
      // disable mid-word
      add(1, 0, 1, 8'hAA, 32'h000000A2, 0, 0);
      add(1, 0, 1, 8'hFF, 32'h000000A2, 0, 0);
      add(0, 0, 1, 8'h77, 32'h000000A2, 0, 1);
      add(0, 0, 0, 8'h00, 32'h000000A2, 0, 0);
      add(1, 0, 1, 8'h99, 32'h000000A2, 0, 0);
      add(1, 0, 1, 8'h01, 32'h000000A2, 0, 0);
      add(1, 0, 1, 8'h02, 32'h000000A2, 0, 0);
      add(1, 0, 1, 8'h03, 32'h000000A2, 0, 0);
      add(1, 0, 1, 8'h04, 32'h01020304, 1, 0);
      // width change mid-word
      add(1, 0, 1, 8'h11, 32'h01020304, 0, 0);
      add(1, 0, 1, 8'h22, 32'h01020304, 0, 0);
      add(1, 1, 1, 8'h12, 32'h01020304, 0, 1);
      add(1, 1, 1, 8'h34, 32'h00001234, 1, 0);
      // reserved width, alone and mid-word
      add(1, 3, 1, 8'hEE, 32'h00001234, 0, 1);
      add(1, 0, 1, 8'h5A, 32'h00001234, 0, 0);
      add(1, 3, 1, 8'hEF, 32'h00001234, 0, 1);
      add(1, 0, 1, 8'h61, 32'h00001234, 0, 0);
      add(1, 0, 1, 8'h62, 32'h00001234, 0, 0);
      add(1, 0, 1, 8'h63, 32'h00001234, 0, 0);
      add(1, 0, 1, 8'h64, 32'h61626364, 1, 0);
      // idle disable with nothing pending: no error
      add(0, 0, 0, 8'h00, 32'h61626364, 0, 0);

      foreach (tbl[i]) begin
         drive(0, tbl[i].enb, tbl[i].pclk, tbl[i].vld, tbl[i].d);
         chk_all($sformatf("vec%0d", i), tbl[i].eo, tbl[i].ev, tbl[i].ee);
      end

      // reset mid-word, then recovery and a reserved-width byte
      drive(0, 1, 0, 0, 8'h00);
      drive(0, 1, 0, 1, 8'hC1);
      drive(0, 1, 0, 1, 8'hC2);
      drive(0, 1, 0, 1, 8'hC3);
      drive(1, 1, 0, 1, 8'hC4);
      chk_all("rst_mid", 32'h0, 1'b0, 1'b0);
      drive(0, 1, 0, 1, 8'hDD);
      chk_all("rst_idle", 32'h0, 1'b0, 1'b0);
      drive(0, 1, 0, 1, 8'h10);
      drive(0, 1, 0, 1, 8'h20);
      drive(0, 1, 0, 1, 8'h30);
      chk_all("rst_part", 32'h0, 1'b0, 1'b0);
      drive(0, 1, 0, 1, 8'h40);
      chk_all("rst_word", 32'h10203040, 1'b1, 1'b0);
      drive(0, 1, 3, 1, 8'h77);
      chk_all("rst_resv", 32'h10203040, 1'b0, 1'b1);

      // randomized run against the model
      drive(1, 0, 0, 0, 8'h00);
      model(1, 0, 0, 0, 8'h00);
      p = 0;
      for (int c = 0; c < 3000; c++) begin
         r = ($urandom_range(0, 199) == 0);
         e = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 15) == 0) p = 2'($urandom_range(0, 3));
         if (p == 3 && $urandom_range(0, 1) == 0) p = 2'($urandom_range(0, 2));
         v = ($urandom_range(0, 9) < 7);
         d = 8'($urandom);
         drive(r, e, p, v, d);
         model(r, e, p, v, d);
         chk_all($sformatf("rnd%0d", c), m_out, m_v, m_e);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
